// File: rtl/ddr_rx_align_ctrl.sv
// IDDR2 lane word aligner: bit-slip sweep until TRAIN_PATTERN repeats; DATA 1 cycle after Q1, no backpressure.
// Optional SLIP_CNT statistics counter enabled by DDR_ALIGN_STATS_EN.
module ddr_rx_align_ctrl #(
  parameter int                WIDTH         = 8,
  parameter logic [WIDTH-1:0]  TRAIN_PATTERN = 8'h5C,
  parameter int                MATCH_COUNT   = 4,
  parameter int                RST_CYCLES    = 4,
  parameter int                MAX_SWEEPS    = 2
) (
  input  logic                     C0,
  input  logic                     R_N,
  input  logic                     START,
  input  logic                     Q0,
  input  logic                     Q1,
  output logic                     DDR_CE,
  output logic                     DDR_R,
  output logic [WIDTH-1:0]         DATA,
  output logic                     DATA_VLD,
  output logic                     LOCKED,
  output logic                     FAIL,
  output logic                     BUSY,
  output logic [$clog2(WIDTH)-1:0] OFFSET,
  output logic [7:0]               SLIP_CNT
);

  localparam int OW  = $clog2(WIDTH);
  localparam int HW  = WIDTH / 2;
  localparam int WCW = $clog2(HW);

  localparam logic [WCW-1:0] WC_LAST    = WCW'(HW - 1);
  localparam logic [OW-1:0]  OFF_LAST   = OW'(WIDTH - 1);
  localparam logic [3:0]     RST_LAST   = 4'(RST_CYCLES - 1);
  localparam logic [3:0]     MATCH_LAST = 4'(MATCH_COUNT - 1);
  localparam logic [2:0]     SWEEP_LAST = 3'(MAX_SWEEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_HUNT, S_VERIFY, S_LOCKED, S_FAIL
  } state_t;

  state_t state_q, state_d;

  // The oldest pair of the 2*WIDTH window only ever exists in sr_next.
  logic [2*WIDTH-3:0] sr;
  logic [2*WIDTH-1:0] sr_next;
  logic [WIDTH-1:0]   cand;
  logic [WCW-1:0]     wc;
  logic [3:0]         rst_cnt;
  logic [3:0]         match_cnt;
  logic [2:0]         sweeps;
  logic [1:0]         skip;
  logic               boundary;
  logic               is_match;
  logic               slip;
  logic               match_first;
  logic               match_inc;

  assign sr_next  = {sr, Q0, Q1};
  assign cand     = sr_next[OFFSET +: WIDTH];
  assign boundary = (wc == WC_LAST);
  assign is_match = (cand == TRAIN_PATTERN);

  always_comb begin
    state_d     = state_q;
    slip        = 1'b0;
    match_first = 1'b0;
    match_inc   = 1'b0;
    DDR_CE      = 1'b0;
    DDR_R       = 1'b0;
    LOCKED      = 1'b0;
    FAIL        = 1'b0;
    BUSY        = 1'b0;

    if (START) begin
      state_d = S_RESET;
    end else begin
      unique case (state_q)
        S_RESET: if (rst_cnt == RST_LAST) state_d = S_HUNT;
        S_HUNT: begin
          if (boundary && skip == 2'd0) begin
            if (is_match) begin
              match_first = 1'b1;
              state_d     = (MATCH_COUNT == 1) ? S_LOCKED : S_VERIFY;
            end else begin
              slip = 1'b1;
            end
          end
        end
        S_VERIFY: begin
          if (boundary) begin
            if (is_match) begin
              match_inc = 1'b1;
              if (match_cnt == MATCH_LAST) state_d = S_LOCKED;
            end else begin
              slip    = 1'b1;
              state_d = S_HUNT;
            end
          end
        end
        default: ;
      endcase
    end

    // Exhausting the last sweep overrides any HUNT return.
    if (slip && OFFSET == OFF_LAST && sweeps == SWEEP_LAST) state_d = S_FAIL;

    unique case (state_q)
      S_RESET:  begin DDR_R  = 1'b1; BUSY = 1'b1; end
      S_HUNT:   begin DDR_CE = 1'b1; BUSY = 1'b1; end
      S_VERIFY: begin DDR_CE = 1'b1; BUSY = 1'b1; end
      S_LOCKED: begin DDR_CE = 1'b1; LOCKED = 1'b1; end
      S_FAIL:   begin DDR_CE = 1'b1; FAIL = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge C0 or negedge R_N) begin
    if (!R_N) begin
      state_q   <= S_IDLE;
      sr        <= '0;
      wc        <= '0;
      DATA      <= '0;
      DATA_VLD  <= 1'b0;
      rst_cnt   <= '0;
      skip      <= '0;
      match_cnt <= '0;
      OFFSET    <= '0;
      sweeps    <= '0;
    end else begin
      state_q  <= state_d;
      sr       <= sr_next[2*WIDTH-3:0];
      DATA_VLD <= boundary && (state_d == S_LOCKED);
      if (boundary) DATA <= cand;

      if ((state_d == S_HUNT && state_q != S_HUNT) || boundary) wc <= '0;
      else                                                      wc <= wc + 1'b1;

      if (START)                  rst_cnt <= '0;
      else if (state_q == S_RESET) rst_cnt <= rst_cnt + 4'd1;

      if (state_q == S_RESET && state_d == S_HUNT)               skip <= 2'd2;
      else if (state_q == S_HUNT && boundary && skip != 2'd0)    skip <= skip - 2'd1;

      if (START) begin
        match_cnt <= '0;
        OFFSET    <= '0;
        sweeps    <= '0;
      end else begin
        if (match_first)    match_cnt <= 4'd1;
        else if (match_inc) match_cnt <= match_cnt + 4'd1;
        if (slip) begin
          if (OFFSET == OFF_LAST) begin
            OFFSET <= '0;
            sweeps <= sweeps + 3'd1;
          end else begin
            OFFSET <= OFFSET + 1'b1;
          end
        end
      end
    end
  end

`ifdef DDR_ALIGN_STATS_EN
  always_ff @(posedge C0 or negedge R_N) begin
    if (!R_N)                          SLIP_CNT <= '0;
    else if (START)                    SLIP_CNT <= '0;
    else if (slip && SLIP_CNT != 8'hFF) SLIP_CNT <= SLIP_CNT + 8'd1;
  end
`else
  assign SLIP_CNT = '0;
`endif

endmodule
